ysyx_24110015_idu: RTL

Instruction decode stage placed directly downstream of the fetch unit. Accepts a fetched `{pc, inst}` beat over a valid/ready handshake, decodes RV32I fields (register indices, sign-extended immediate, operation class, illegal flag) and presents the registered result to the execute stage. A two-entry skid buffer keeps the full handshake rate under backpressure. A flush input discards all buffered beats on a redirect.

---
 rtl/ysyx_24110015_idu.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24110015_idu.sv
// ysyx_24110015_idu: RV32I instruction decode stage.
// Decodes a fetched {pc, inst} beat into register indices, immediate and
// operation class, and holds results in a two-entry skid buffer
// (primary P drives out_*, skid S catches a beat while P is held).
//
// Handshake: a beat moves on a port in any cycle where valid && ready are
// both high at the rising edge. valid never waits on ready, and out_* stays
// stable while out_valid && !out_ready. in_ready is a pure register output
// (low only when the skid entry is occupied).
module ysyx_24110015_idu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_cls,
   output logic            out_illegal,
   output logic [31:0]     out_count,
   output logic [1:0]      dbg_state
);

   // State bit 0 = P valid, bit 1 = S valid; S is never valid without P.
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_TWO   = 2'b11;

   localparam logic [3:0] CLS_LUI    = 4'd0;
   localparam logic [3:0] CLS_AUIPC  = 4'd1;
   localparam logic [3:0] CLS_JAL    = 4'd2;
   localparam logic [3:0] CLS_JALR   = 4'd3;
   localparam logic [3:0] CLS_BRANCH = 4'd4;
   localparam logic [3:0] CLS_LOAD   = 4'd5;
   localparam logic [3:0] CLS_STORE  = 4'd6;
   localparam logic [3:0] CLS_OPIMM  = 4'd7;
   localparam logic [3:0] CLS_OP     = 4'd8;
   localparam logic [3:0] CLS_SYSTEM = 4'd9;
   localparam logic [3:0] CLS_FENCE  = 4'd10;
   localparam logic [3:0] CLS_ILL    = 4'd15;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;

   logic [XLEN-1:0] r_p_pc;
   logic [31:0]     r_p_inst;
   logic [XLEN-1:0] r_p_imm;
   logic [3:0]      r_p_cls;
   logic [XLEN-1:0] r_s_pc;
   logic [31:0]     r_s_inst;
   logic [XLEN-1:0] r_s_imm;
   logic [3:0]      r_s_cls;
   logic [31:0]     r_count;

   logic [4:0]      w_opcode;
   logic [3:0]      w_cls;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_b;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_imm_j;

   logic            w_accept;
   logic            w_drain;
   logic            w_load_p_in;
   logic            w_load_p_s;
   logic            w_load_s;

   // Immediate format extraction, sign-extended from the top bit of each.
   assign w_opcode = in_inst[6:2];
   assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
   assign w_imm_u  = {in_inst[31:12], 12'b0};
   assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};

   // Classify the incoming word and pick its immediate; illegal words get imm 0.
   always_comb begin
      w_cls = CLS_ILL;
      w_imm = '0;
      if (in_inst[1:0] == 2'b11) begin
         case (w_opcode)
            5'b01101: begin w_cls = CLS_LUI;    w_imm = w_imm_u; end
            5'b00101: begin w_cls = CLS_AUIPC;  w_imm = w_imm_u; end
            5'b11011: begin w_cls = CLS_JAL;    w_imm = w_imm_j; end
            5'b11001: begin w_cls = CLS_JALR;   w_imm = w_imm_i; end
            5'b11000: begin w_cls = CLS_BRANCH; w_imm = w_imm_b; end
            5'b00000: begin w_cls = CLS_LOAD;   w_imm = w_imm_i; end
            5'b01000: begin w_cls = CLS_STORE;  w_imm = w_imm_s; end
            5'b00100: begin w_cls = CLS_OPIMM;  w_imm = w_imm_i; end
            5'b01100: begin w_cls = CLS_OP;     w_imm = '0;      end
            5'b11100: begin w_cls = CLS_SYSTEM; w_imm = w_imm_i; end
            5'b00011: begin w_cls = CLS_FENCE;  w_imm = w_imm_i; end
            default:  begin w_cls = CLS_ILL;    w_imm = '0;      end
         endcase
      end
   end

   assign w_accept = in_valid && in_ready && !flush;
   assign w_drain  = out_valid && out_ready;

   // Buffer occupancy register; reset returns to EMPTY.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_EMPTY;
      else      r_state <= w_state_nxt;
   end

   // Occupancy transitions; flush empties the buffer ahead of any handshake.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_drain)      w_state_nxt = ST_TWO;
               else if (!w_accept && w_drain) w_state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (w_drain) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs and entry load strobes derived from the current state.
   always_comb begin
      in_ready    = !r_state[1];
      out_valid   = r_state[0];
      w_load_p_in = 1'b0;
      w_load_s    = 1'b0;
      w_load_p_s  = 1'b0;
      case (r_state)
         ST_EMPTY: w_load_p_in = w_accept;
         ST_ONE: begin
            w_load_p_in = w_accept && w_drain;
            w_load_s    = w_accept && !w_drain;
         end
         ST_TWO:   w_load_p_s = w_drain;
         default: ;
      endcase
   end

   // Primary and skid entry payloads; P refills from input or from S.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_p_pc   <= '0;
         r_p_inst <= '0;
         r_p_imm  <= '0;
         r_p_cls  <= '0;
         r_s_pc   <= '0;
         r_s_inst <= '0;
         r_s_imm  <= '0;
         r_s_cls  <= '0;
      end else begin
         if (w_load_p_in) begin
            r_p_pc   <= in_pc;
            r_p_inst <= in_inst;
            r_p_imm  <= w_imm;
            r_p_cls  <= w_cls;
         end else if (w_load_p_s) begin
            r_p_pc   <= r_s_pc;
            r_p_inst <= r_s_inst;
            r_p_imm  <= r_s_imm;
            r_p_cls  <= r_s_cls;
         end
         if (w_load_s) begin
            r_s_pc   <= in_pc;
            r_s_inst <= in_inst;
            r_s_imm  <= w_imm;
            r_s_cls  <= w_cls;
         end
      end
   end

   // Delivered-beat counter; counts drains even in a flush cycle, wraps freely.
   always_ff @(posedge clk) begin
      if (!rst)         r_count <= '0;
      else if (w_drain) r_count <= r_count + 32'd1;
   end

   assign out_pc      = r_p_pc;
   assign out_inst    = r_p_inst;
   assign out_rs1     = r_p_inst[19:15];
   assign out_rs2     = r_p_inst[24:20];
   assign out_rd      = r_p_inst[11:7];
   assign out_funct3  = r_p_inst[14:12];
   assign out_imm     = r_p_imm;
   assign out_cls     = r_p_cls;
   assign out_illegal = (r_p_cls == CLS_ILL);
   assign out_count   = r_count;
   assign dbg_state   = r_state;

endmodule
